mw_countdown_timer: RTL and testbench

//  Cooking-time countdown for the microwave: keypad digits load an MM:SS BCD value, which

---
 rtl/mw_countdown_timer.sv | 137 +++++++++++++
 tb/tb_mw_countdown_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mw_countdown_timer.sv
// ============================================================================
// mw_countdown_timer
// ----------------------------------------------------------------------------
// Cooking-time countdown for the microwave. Keypad digits shift into an MM:SS
// BCD value while the magnetron is off. While it is on, the value counts down
// by one second every TICKS_PER_SEC clock cycles. A one-cycle done pulse is
// raised when a decrement reaches 00:00.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per one-second decrement (>= 2)
//   PRE_W          prescaler width; must hold TICKS_PER_SEC-1
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high; clears all state
//   i_clearn       synchronous clear, active-low (keypad Clear)
//   i_digit_valid  one-cycle strobe: i_key_digit holds a new keypad digit
//   i_key_digit    BCD digit entered on the keypad
//   i_enable       count enable (magnetron on)
//   o_min_tens     BCD minutes, tens digit
//   o_min_ones     BCD minutes, ones digit
//   o_sec_tens     BCD seconds, tens digit
//   o_sec_ones     BCD seconds, ones digit
//   o_zero         level: all four digits are 0 (combinational)
//   o_timer_done   registered one-cycle pulse: countdown reached 00:00
// ============================================================================
module mw_countdown_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRE_W         = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clearn,
    input  logic       i_digit_valid,
    input  logic [3:0] i_key_digit,
    input  logic       i_enable,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic       o_zero,
    output logic       o_timer_done
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [3:0]       r_mt, r_mo, r_st, r_so;
    logic [PRE_W-1:0] r_pre;
    logic             r_done;

    logic             w_zero;
    logic             w_tick;
    logic             w_key_ok;
    logic             w_b0, w_b1, w_b2;
    logic [3:0]       w_mt_dec, w_mo_dec, w_st_dec, w_so_dec;
    logic             w_dec_zero;

    assign w_zero   = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
    // zero gates the tick, so min_tens can never underflow below.
    assign w_tick   = (r_pre == PRE_LAST) && i_enable && !w_zero;
    assign w_key_ok = i_digit_valid && (i_key_digit <= 4'd9);

    // BCD borrow chain. sec_tens wraps to 5 (seconds field), the others to 9.
    // sec_tens values 6..9 from keypad entry simply decrement by one.
    always_comb begin
        w_b0     = (r_so == 4'd0);
        w_so_dec = w_b0 ? 4'd9 : r_so - 4'd1;

        w_b1     = w_b0 && (r_st == 4'd0);
        w_st_dec = r_st;
        if (w_b0)
            w_st_dec = (r_st == 4'd0) ? 4'd5 : r_st - 4'd1;

        w_b2     = w_b1 && (r_mo == 4'd0);
        w_mo_dec = r_mo;
        if (w_b1)
            w_mo_dec = (r_mo == 4'd0) ? 4'd9 : r_mo - 4'd1;

        w_mt_dec = r_mt;
        if (w_b2)
            w_mt_dec = r_mt - 4'd1;
    end

    assign w_dec_zero = ({w_mt_dec, w_mo_dec, w_st_dec, w_so_dec} == 16'h0000);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mt   <= 4'd0;
            r_mo   <= 4'd0;
            r_st   <= 4'd0;
            r_so   <= 4'd0;
            r_pre  <= '0;
            r_done <= 1'b0;
        end else if (!i_clearn) begin
            r_mt   <= 4'd0;
            r_mo   <= 4'd0;
            r_st   <= 4'd0;
            r_so   <= 4'd0;
            r_pre  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_enable) begin
                // Counting: keypad is locked out while the magnetron runs.
                if (w_zero) begin
                    r_pre <= '0;
                end else if (w_tick) begin
                    r_pre  <= '0;
                    r_mt   <= w_mt_dec;
                    r_mo   <= w_mo_dec;
                    r_st   <= w_st_dec;
                    r_so   <= w_so_dec;
                    r_done <= w_dec_zero;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end else begin
                // Paused: the partial second is discarded.
                r_pre <= '0;
                if (w_key_ok) begin
                    r_mt <= r_mo;
                    r_mo <= r_st;
                    r_st <= r_so;
                    r_so <= i_key_digit;
                end
            end
        end
    end

    assign o_min_tens   = r_mt;
    assign o_min_ones   = r_mo;
    assign o_sec_tens   = r_st;
    assign o_sec_ones   = r_so;
    assign o_zero       = w_zero;
    assign o_timer_done = r_done;

endmodule

// File: tb/tb_mw_countdown_timer.sv
module tb_mw_countdown_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] key_digit;
    logic       enable;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       zero, timer_done;

    int checks = 0;
    int errors = 0;

    mw_countdown_timer #(.TICKS_PER_SEC(TPS), .PRE_W(3)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_clearn      (clearn),
        .i_digit_valid (digit_valid),
        .i_key_digit   (key_digit),
        .i_enable      (enable),
        .o_min_tens    (min_tens),
        .o_min_ones    (min_ones),
        .o_sec_tens    (sec_tens),
        .o_sec_ones    (sec_ones),
        .o_zero        (zero),
        .o_timer_done  (timer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clearn;
        logic        dv;
        logic [3:0]  key;
        logic        en;
        logic [15:0] exp_val;
        logic        exp_zero;
        logic        exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic cn, input logic dv, input logic [3:0] k,
                                input logic en, input logic [15:0] ev,
                                input logic ez, input logic ed);
        vec_t v;
        v.clearn = cn; v.dv = dv; v.key = k; v.en = en;
        v.exp_val = ev; v.exp_zero = ez; v.exp_done = ed;
        tbl.push_back(v);
    endfunction

    // Helpers for common vector shapes.
    function automatic void key(input logic [3:0] k, input logic [15:0] ev);
        add(1'b1, 1'b1, k, 1'b0, ev, ev == 16'h0, 1'b0);
    endfunction

    function automatic void run(input logic [15:0] ev, input logic ed);
        add(1'b1, 1'b0, 4'd0, 1'b1, ev, ev == 16'h0, ed);
    endfunction

    function automatic void clr();
        add(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    endfunction

    task automatic check(input string nm, input logic [15:0] ev,
                         input logic ez, input logic ed);
        logic [15:0] av;
        av = {min_tens, min_ones, sec_tens, sec_ones};
        checks++;
        if (av !== ev || zero !== ez || timer_done !== ed) begin
            errors++;
            $display("FAIL %s: got val=%h zero=%b done=%b, want val=%h zero=%b done=%b",
                     nm, av, zero, timer_done, ev, ez, ed);
        end
    endtask

    task automatic drive(input logic cn, input logic dv, input logic [3:0] k, input logic en);
        @(negedge clk);
        clearn = cn; digit_valid = dv; key_digit = k; enable = en;
    endtask

    task automatic step_chk(input string nm, input logic cn, input logic dv,
                            input logic [3:0] k, input logic en, input logic [15:0] ev,
                            input logic ez, input logic ed);
        drive(cn, dv, k, en);
        @(posedge clk);
        #1;
        check(nm, ev, ez, ed);
    endtask

    initial begin
        reset = 1'b1; clearn = 1'b1; digit_valid = 1'b0; key_digit = 4'd0; enable = 1'b0;

        // Entry
        key(4'd1, 16'h0001);
        key(4'd2, 16'h0012);
        key(4'd3, 16'h0123);
        key(4'd0, 16'h1230);
        key(4'hA, 16'h1230);                               // illegal key ignored
        add(1'b1, 1'b1, 4'd5, 1'b1, 16'h1230, 1'b0, 1'b0); // key ignored while counting
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h1230, 1'b0, 1'b0); // pause drops partial second
        clr();
        // Borrow 10:00 -> 09:59
        key(4'd1, 16'h0001); key(4'd0, 16'h0010); key(4'd0, 16'h0100); key(4'd0, 16'h1000);
        run(16'h1000, 0); run(16'h1000, 0); run(16'h1000, 0); run(16'h0959, 0);
        clr();
        // 00:90 -> 00:89
        key(4'd9, 16'h0009); key(4'd0, 16'h0090);
        run(16'h0090, 0); run(16'h0090, 0); run(16'h0090, 0); run(16'h0089, 0);
        clr();
        // Done at 00:00, then hold with enable still high
        key(4'd2, 16'h0002);
        run(16'h0002, 0); run(16'h0002, 0); run(16'h0002, 0); run(16'h0001, 0);
        run(16'h0001, 0); run(16'h0001, 0); run(16'h0001, 0); run(16'h0000, 1);
        run(16'h0000, 0); run(16'h0000, 0); run(16'h0000, 0); run(16'h0000, 0);
        run(16'h0000, 0);
        // Pause
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
        key(4'd5, 16'h0005);
        run(16'h0005, 0); run(16'h0005, 0); run(16'h0005, 0); run(16'h0004, 0);
        run(16'h0004, 0); run(16'h0004, 0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h0004, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h0004, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h0004, 1'b0, 1'b0);
        run(16'h0004, 0); run(16'h0004, 0); run(16'h0004, 0); run(16'h0003, 0);
        // Pause with partial second (pre=2), resume needs a full period
        run(16'h0003, 0); run(16'h0003, 0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 16'h0003, 1'b0, 1'b0);
        run(16'h0003, 0); run(16'h0003, 0); run(16'h0003, 0); run(16'h0002, 0);
        clr();
        // Clear wins over a coincident tick at 00:01
        key(4'd1, 16'h0001);
        run(16'h0001, 0); run(16'h0001, 0); run(16'h0001, 0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run(16'h0000, 0); run(16'h0000, 0); run(16'h0000, 0); run(16'h0000, 0);
        run(16'h0000, 0);
        // Clear wins over a coincident digit
        key(4'd7, 16'h0007);
        add(1'b0, 1'b1, 4'd3, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Range: 99:99 -> 99:98, 99:90 -> 99:89, 5th digit discards old min_tens
        key(4'd9, 16'h0009); key(4'd9, 16'h0099); key(4'd9, 16'h0999); key(4'd9, 16'h9999);
        run(16'h9999, 0); run(16'h9999, 0); run(16'h9999, 0); run(16'h9998, 0);
        add(1'b1, 1'b1, 4'd0, 1'b0, 16'h9980, 1'b0, 1'b0);
        clr();
        key(4'd9, 16'h0009); key(4'd9, 16'h0099); key(4'd9, 16'h0999); key(4'd0, 16'h9990);
        run(16'h9990, 0); run(16'h9990, 0); run(16'h9990, 0); run(16'h9989, 0);
        clr();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step_chk($sformatf("vec%0d", i), tbl[i].clearn, tbl[i].dv, tbl[i].key,
                     tbl[i].en, tbl[i].exp_val, tbl[i].exp_zero, tbl[i].exp_done);
        end

        // Reset mid-count at 01:23 with enable high: clears asynchronously.
        step_chk("rst_ld1", 1, 1, 4'd1, 0, 16'h0001, 0, 0);
        step_chk("rst_ld2", 1, 1, 4'd2, 0, 16'h0012, 0, 0);
        step_chk("rst_ld3", 1, 1, 4'd3, 0, 16'h0123, 0, 0);
        step_chk("rst_run1", 1, 0, 4'd0, 1, 16'h0123, 0, 0);
        step_chk("rst_run2", 1, 0, 4'd0, 1, 16'h0123, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // After release a fresh load needs a full period for its first tick.
        step_chk("post_rst_ld", 1, 1, 4'd1, 0, 16'h0001, 0, 0);
        step_chk("post_rst_c1", 1, 0, 4'd0, 1, 16'h0001, 0, 0);
        step_chk("post_rst_c2", 1, 0, 4'd0, 1, 16'h0001, 0, 0);
        step_chk("post_rst_c3", 1, 0, 4'd0, 1, 16'h0001, 0, 0);
        step_chk("post_rst_c4", 1, 0, 4'd0, 1, 16'h0000, 1, 1);
        step_chk("post_rst_c5", 1, 0, 4'd0, 1, 16'h0000, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
